// File: rtl/tmds_rx_decode.sv
// rtl/tmds_rx_decode.sv - TMDS channel-0 receiver: word alignment, character decode, raster recovery
module tmds_rx_decode #(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 1024,
    parameter int LOSS_WIN   = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_din,
    output logic       o_locked,
    output logic [3:0] o_ofs,
    output logic       o_de,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [7:0] o_data,
    output logic [9:0] o_sx,
    output logic [9:0] o_sy
);
    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TMR_W = $clog2((LOSS_WIN > SEARCH_WIN) ? LOSS_WIN : SEARCH_WIN);
    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(CTRL_RUN - 1);
    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_WIN - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_WIN - 1);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    function automatic logic is_token(input logic [9:0] w);
        case (w)
            10'b1101010100, 10'b0010101011,
            10'b0101010100, 10'b1010101011: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] token_ctrl(input logic [9:0] w);
        case (w)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    state_t           r_state, w_state_n;
    logic [9:0]       r_prev, r_w1;
    logic [3:0]       r_ofs, w_ofs_n;
    logic [RUN_W-1:0] r_run, w_run_n;
    logic [TMR_W-1:0] r_tmr, w_tmr_n;
    logic             r_de2, r_hs2, r_vs2;
    logic [7:0]       r_data2;
    logic [9:0]       r_sx, r_sy;

    logic [19:0] w_cat;
    logic [9:0]  w_win;
    logic        w_win_tok, w_run_full, w_locked;
    logic        w_s1_tok;
    logic [1:0]  w_s1_ctrl;
    logic [7:0]  w_v, w_dec, w_data_n;
    logic        w_de_n, w_hs_n, w_vs_n;
    logic [9:0]  w_sx_n, w_sy_n;

    // din[0] is the earliest bit, so the previous word sits in the low half of the window
    assign w_cat      = {i_din, r_prev};
    assign w_win      = 10'(w_cat >> r_ofs);
    assign w_win_tok  = is_token(w_win);
    assign w_run_full = w_win_tok && (r_run >= RUN_LAST);
    assign w_locked   = (r_state == S_LOCKED);

    assign w_s1_tok  = is_token(r_w1);
    assign w_s1_ctrl = token_ctrl(r_w1);

    always_comb begin
        w_dec    = '0;
        w_v      = r_w1[9] ? ~r_w1[7:0] : r_w1[7:0];
        w_dec[0] = w_v[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_w1[8] ? (w_v[i] ^ w_v[i-1]) : ~(w_v[i] ^ w_v[i-1]);
        end
    end

    assign w_de_n   = ~w_s1_tok;
    assign w_hs_n   = w_s1_tok ? w_s1_ctrl[0] : r_hs2;
    assign w_vs_n   = w_s1_tok ? w_s1_ctrl[1] : r_vs2;
    assign w_data_n = w_s1_tok ? 8'h00 : w_dec;

    // Coordinates are computed from the values entering stage 2 so they line up with de
    always_comb begin
        w_sx_n = '0;
        w_sy_n = r_sy;
        if (w_de_n && r_de2) begin
            w_sx_n = r_sx + 10'd1;
        end
        if (w_vs_n && !r_vs2) begin
            w_sy_n = '0;
        end else if (r_de2 && !w_de_n) begin
            w_sy_n = r_sy + 10'd1;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ofs_n   = r_ofs;
        w_tmr_n   = r_tmr + 1'b1;
        w_run_n   = '0;
        if (w_win_tok) begin
            w_run_n = (r_run == RUN_FULL) ? RUN_FULL : r_run + 1'b1;
        end
        case (r_state)
            S_SEARCH: begin
                if (w_run_full) begin
                    w_state_n = S_LOCKED;
                    w_tmr_n   = '0;
                end else if (r_tmr == SEARCH_LAST) begin
                    w_ofs_n = (r_ofs == 4'd9) ? 4'd0 : r_ofs + 4'd1;
                    w_tmr_n = '0;
                    w_run_n = '0;
                end
            end
            S_LOCKED: begin
                if (w_run_full) begin
                    w_tmr_n = '0;
                end else if (r_tmr == LOSS_LAST) begin
                    w_state_n = S_SEARCH;
                    w_tmr_n   = '0;
                    w_run_n   = '0;
                end
            end
            default: w_state_n = S_SEARCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_SEARCH;
            r_prev  <= '0;
            r_w1    <= '0;
            r_ofs   <= '0;
            r_run   <= '0;
            r_tmr   <= '0;
            r_de2   <= 1'b0;
            r_hs2   <= 1'b0;
            r_vs2   <= 1'b0;
            r_data2 <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            r_state <= w_state_n;
            r_prev  <= i_din;
            r_w1    <= w_win;
            r_ofs   <= w_ofs_n;
            r_run   <= w_run_n;
            r_tmr   <= w_tmr_n;
            r_de2   <= w_de_n;
            r_hs2   <= w_hs_n;
            r_vs2   <= w_vs_n;
            r_data2 <= w_data_n;
            r_sx    <= w_sx_n;
            r_sy    <= w_sy_n;
        end
    end

    assign o_locked = w_locked;
    assign o_ofs    = r_ofs;
    assign o_de     = w_locked & r_de2;
    assign o_hsync  = w_locked & r_hs2;
    assign o_vsync  = w_locked & r_vs2;
    assign o_data   = w_locked ? r_data2 : 8'h00;
    assign o_sx     = w_locked ? r_sx : 10'd0;
    assign o_sy     = w_locked ? r_sy : 10'd0;
endmodule

// File: tb/tb_tmds_rx_decode.sv
// tb/tb_tmds_rx_decode.sv - randomized self-checking bench for tmds_rx_decode
module tb_tmds_rx_decode;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] din = '0;
    logic       o_locked, o_de, o_hsync, o_vsync;
    logic [3:0] o_ofs;
    logic [7:0] o_data;
    logic [9:0] o_sx, o_sy;

    int n_checks = 0;
    int n_errors = 0;
    int disp = 0;
    logic [30:0] exp_q[$];

    always #5 clk = ~clk;

    tmds_rx_decode dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din),
        .o_locked(o_locked), .o_ofs(o_ofs), .o_de(o_de), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_data(o_data), .o_sx(o_sx), .o_sy(o_sy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] tok(input int c);
        case (c)
            0:       return 10'b1101010100;
            1:       return 10'b0010101011;
            2:       return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Standard DVI transmit encoder; the receiver must return the original byte
    task automatic tmds_enc(input logic [7:0] d, output logic [9:0] q);
        int n1, n1q;
        logic [8:0] qm;
        n1 = $countones(d);
        qm = '0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        if (disp == 0 || n1q == 4) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? (2 * n1q - 8) : (8 - 2 * n1q);
        end else if ((disp > 0 && n1q > 4) || (disp < 0 && n1q < 4)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + (8 - 2 * n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + (2 * n1q - 8);
        end
    endtask

    task automatic send(input logic [9:0] w);
        din = w;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rsend(input logic [9:0] w, input logic [30:0] e);
        send(w);
        exp_q.push_back(e);
        if (exp_q.size() > 2) begin
            check("raster", {o_de, o_hsync, o_vsync, o_data, o_sx, o_sy}, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [9:0] w, rot, t;
        logic [7:0] b;
        logic [1:0] cb;
        int lock_n;

        #2 rst_n = 1'b0;
        #1 check("reset_outs", {o_locked, o_ofs, o_de, o_hsync, o_vsync, o_data, o_sx, o_sy}, 36'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) send(10'd0);
        check("zero_no_lock", o_locked, 1'b0);

        reset_dut();
        for (int i = 0; i < 20; i++) begin
            send(tok(0));
            if (i == 7) check("lock_early", o_locked, 1'b0);
            if (i == 8) check("lock_edge", o_locked, 1'b1);
        end
        check("lock_state", {o_ofs, o_hsync, o_vsync, o_de, o_data}, 15'd0);

        send(10'b0100000000);
        send(10'b1100000000);
        check("pipe_latency", o_de, 1'b0);
        send(10'b0000000000);
        check("dec_00", {o_locked, o_de, o_data}, {2'b11, 8'h00});
        send(tok(0));
        check("dec_01", {o_de, o_data}, {1'b1, 8'h01});
        send(tok(0));
        check("dec_fe", {o_de, o_data}, {1'b1, 8'hFE});

        // Two short frames; the second ends in a 1100-pixel line so sx wraps
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 3; l++) begin
                for (int k = 0; k < 160; k++) begin
                    cb = (l == 0 && k < 16) ? 2'b11 : 2'b01;
                    rsend(tok(int'(cb)), {1'b0, cb[0], cb[1], 8'h00, 10'd0, 10'(l)});
                end
                for (int p = 0; p < ((f == 1 && l == 2) ? 1100 : 640); p++) begin
                    b = 8'($urandom);
                    tmds_enc(b, w);
                    rsend(w, {1'b1, 1'b1, 1'b0, b, 10'(p), 10'(l)});
                end
            end
        end
        exp_q.delete();

        for (int i = 0; i < 10; i++) send(10'b0100000000);
        for (int i = 0; i < 8; i++) send(tok(0));
        for (int n = 1; n <= 3100; n++) begin
            send(10'b0100000000);
            if (n == 2048) check("loss_hold", o_locked, 1'b1);
            if (n == 2049) begin
                check("loss_drop", {o_locked, o_de, o_hsync, o_vsync, o_data, o_sx, o_sy}, 32'd0);
                check("loss_ofs", o_ofs, 4'd0);
            end
        end
        check("resume_ofs", {o_locked, o_ofs}, {1'b0, 4'd1});

        // Token stream delayed by 3 bits: din[j] = tok[(j+7) mod 10]
        t = tok(0);
        for (int j = 0; j < 10; j++) rot[j] = t[(j + 7) % 10];
        reset_dut();
        lock_n = 0;
        for (int n = 1; n <= 3082 && lock_n == 0; n++) begin
            send(rot);
            if (n == 1023) check("rot_ofs0", o_ofs, 4'd0);
            if (n == 1024) check("rot_ofs1", o_ofs, 4'd1);
            if (n == 2048) check("rot_ofs2", o_ofs, 4'd2);
            if (o_locked) lock_n = n;
        end
        check("rot_lock", {o_locked, o_ofs}, {1'b1, 4'd3});
        check("rot_lock_cycle", lock_n, 3080);
        for (int i = 0; i < 5; i++) send(rot);

        rst_n = 1'b0;
        #1 check("async_rst", {o_locked, o_ofs, o_de, o_hsync, o_vsync, o_data, o_sx, o_sy}, 36'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) send(10'd0);
        check("post_rst_idle", {o_locked, o_ofs}, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tmds_rx_decode.md
Name: tmds_rx_decode

Overview:
- Receive-side counterpart of the HDMI/VGA transmit path for one TMDS channel, nominally blue (channel 0), which carries HSYNC/VSYNC.
- Takes raw 10-bit parallel words from a 1:10 deserializer whose word boundary is unknown and finds the boundary using control-token runs.
- Decodes TMDS characters back to 8-bit pixel data and control bits, and recovers DE/HSYNC/VSYNC plus sx/sy pixel coordinates matching the transmitter's 640x480 raster.
- Sits between the deserializer and any capture/compare logic in the pixel-clock domain.

Parameters:
- CTRL_RUN, 8: consecutive control tokens needed to declare lock.
- SEARCH_WIN, 1024: cycles spent at one bit offset before advancing to the next.
- LOSS_WIN, 2048: cycles in LOCKED without a full CTRL_RUN token run before dropping lock.

Ports:
- clk  input  1  pixel clock, one 10-bit word per cycle.
- rst  input  1  asynchronous, active-low reset.
- din  input  10  raw deserialized bits; din[0] is the earliest received bit.
- locked  output  1  word alignment achieved.
- ofs  output  4  current bit offset, 0..9.
- de  output  1  data enable (a data character was received).
- hsync  output  1  decoded C0.
- vsync  output  1  decoded C1.
- data  output  8  decoded pixel byte.
- sx  output  10  pixel column within active line.
- sy  output  10  active line index.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, ofs=0, state SEARCH, all counters and pipeline registers 0.
- Alignment window:
  - prev <= din every cycle.
  - cat = {din, prev} (20 bits); w = cat[ofs+9 : ofs].
  - w is registered (stage 1), then decoded and registered (stage 2).
  - A word fully present in din at cycle N appears decoded on the outputs at cycle N+2 when ofs=0.
- Control tokens (w[9:0] written MSB first):
  - 1101010100 -> C=00
  - 0010101011 -> C=01
  - 0101010100 -> C=10
  - 1010101011 -> C=11
  - C[0]=hsync, C[1]=vsync.
- Data decode for any non-token w:
  - If w[9]=1, invert w[7:0] to get v; otherwise v=w[7:0].
  - data[0]=v[0].
  - For i=1..7: data[i] = w[8] ? v[i]^v[i-1] : ~(v[i]^v[i-1]).
  - Output de=1. hsync/vsync hold their last decoded token values.
- Token word output: de=0, data=0, hsync/vsync updated from C.
- FSM, SEARCH:
  - run counter increments on each token and clears on a non-token.
  - When run reaches CTRL_RUN: go to LOCKED, set locked=1 on the same edge.
  - Otherwise, when the timer reaches SEARCH_WIN-1: ofs <= (ofs==9) ? 0 : ofs+1, and clear timer and run.
- FSM, LOCKED:
  - ofs is frozen.
  - Timer clears whenever run reaches CTRL_RUN.
  - If the timer reaches LOSS_WIN-1: go to SEARCH, locked=0, clear run and timer, ofs unchanged.
- While locked=0:
  - de, hsync, vsync, data, sx and sy are forced to 0.
  - The decode pipeline keeps running, so the first post-lock output is valid immediately.
- Coordinates (evaluated on the stage-2 de/vsync):
  - sx = count of de=1 cycles since the de rising edge: 0 on the first pixel, incrementing each cycle while de=1, 0 when de=0.
  - sy increments on each de falling edge and clears on each vsync rising edge. A simultaneous vsync rise and de fall gives sy=0.
  - sx and sy are 10-bit and wrap 1023 -> 0.
- Bit-slip: an ofs change takes effect on the next window and discards no words. Garbage produced during the change is absorbed by the search.

Test Plan:
- Reset and hold: assert rst=0 mid-stream while locked -> all outputs 0 and ofs=0 within the same cycle. Release with zero din -> locked stays 0.
- Aligned lock: feed 20 tokens 1101010100 with ofs=0 -> locked=1 on the 8th token's stage-1 edge, ofs=0, hsync=0, vsync=0, de=0.
- Rotated stream: the same token stream rotated by 3 bits -> ofs steps 0,1,2,3 at SEARCH_WIN boundaries and locks at ofs=3 within 3*1024+10 cycles.
- Data decode, locked and aligned:
  - 0100000000 -> data=0x00, de=1.
  - 1100000000 -> data=0x01.
  - 0000000000 -> data=0xFE.
  - Each appears 2 cycles after input.
- Raster: 160 tokens C=01, 640 data words, repeated 480 lines; a C=11 token burst at line 0 start -> sx runs 0..639 each line, sy runs 0..479 and returns to 0 on the vsync rise, hsync=1 during C=01.
- Loss of lock: after lock, 3000 consecutive data words -> locked=0 exactly LOSS_WIN cycles after the last completed token run. Outputs go to 0 and search resumes from the retained ofs.
